// File: rtl/uart_tx_arbiter.sv
// Frame-aware two-port round-robin arbiter in front of the uart_wrapper byte port.
// A grant is held from the first byte to last/MAX_LEN, so frames from the two requesters never interleave.
module uart_tx_arbiter #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 9
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data0,
  input  logic       i_valid0,
  input  logic       i_last0,
  output logic       o_ready0,
  input  logic [7:0] i_data1,
  input  logic       i_valid1,
  input  logic       i_last1,
  output logic       o_ready1,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [1:0] o_grant,
  output logic       o_trunc
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;
  logic             xfer;
  logic             last_sel;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_valid0 && i_valid1) state_d = prio_q ? GNT1 : GNT0;
        else if (i_valid0)        state_d = GNT0;
        else if (i_valid1)        state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (xfer) begin
          // Release on last, or force-release on the MAX_LEN-th byte of the grant.
          if (last_sel || cnt_q == CNT_W'(MAX_LEN - 1)) begin
            state_d = IDLE;
            prio_d  = (state_q == GNT0);
            cnt_d   = '0;
            trunc_d = !last_sel;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tx_data  = 8'h00;
    o_tx_valid = 1'b0;
    o_ready0   = 1'b0;
    o_ready1   = 1'b0;
    o_grant    = 2'b00;
    last_sel   = 1'b0;
    unique case (state_q)
      GNT0: begin
        o_tx_data  = i_data0;
        o_tx_valid = i_valid0;
        o_ready0   = i_tx_ready;
        o_grant    = 2'b01;
        last_sel   = i_last0;
      end
      GNT1: begin
        o_tx_data  = i_data1;
        o_tx_valid = i_valid1;
        o_ready1   = i_tx_ready;
        o_grant    = 2'b10;
        last_sel   = i_last1;
      end
      default: ;
    endcase
  end

  assign xfer    = o_tx_valid && i_tx_ready;
  assign o_trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed frame scenarios plus random traffic,
// compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 3;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_data0, i_data1;
  logic       i_valid0, i_valid1, i_last0, i_last1;
  logic       o_ready0, o_ready1;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;
  logic [1:0] o_grant;
  logic       o_trunc;

  uart_tx_arbiter #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_data0(i_data0), .i_valid0(i_valid0), .i_last0(i_last0), .o_ready0(o_ready0),
    .i_data1(i_data1), .i_valid1(i_valid1), .i_last1(i_last1), .o_ready1(o_ready1),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_grant(o_grant), .o_trunc(o_trunc)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  beat_t      q0[$], q1[$];
  logic [7:0] log_q[$], exp_log[$], exp_q[$];
  int         trunc_seen;
  int         ready_mode;
  int         ready_phase;
  bit         gap_mode;

  // Reference model: who owns the port, bytes sent in this grant, whose turn is next.
  int   owner;
  int   m_prio;
  int   m_sent;
  logic m_trunc;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner   = -1;
    m_prio  = 0;
    m_sent  = 0;
    m_trunc = 1'b0;
  endtask

  task automatic drive();
    if (q0.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
      i_valid0 = 1'b1; i_data0 = q0[0].d; i_last0 = q0[0].l;
    end else begin
      i_valid0 = 1'b0; i_data0 = 8'($urandom); i_last0 = 1'($urandom);
    end
    if (q1.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
      i_valid1 = 1'b1; i_data1 = q1[0].d; i_last1 = q1[0].l;
    end else begin
      i_valid1 = 1'b0; i_data1 = 8'($urandom); i_last1 = 1'($urandom);
    end
    case (ready_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = (ready_phase % 3 == 0);
      default: i_tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Checks outputs at the falling edge, then advances the model across the next rising edge.
  task automatic cycle();
    logic [1:0] eg;
    logic       ev, er0, er1, lst;
    logic [7:0] ed;
    @(negedge i_clk);
    if (i_rst) model_reset();
    eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    ev  = (owner == 0) ? i_valid0 : (owner == 1) ? i_valid1 : 1'b0;
    ed  = (owner == 0) ? i_data0 : (owner == 1) ? i_data1 : 8'h00;
    er0 = (owner == 0) && i_tx_ready;
    er1 = (owner == 1) && i_tx_ready;
    check("grant", 32'(o_grant), 32'(eg));
    check("tx_valid", 32'(o_tx_valid), 32'(ev));
    check("tx_data", 32'(o_tx_data), 32'(ed));
    check("ready0", 32'(o_ready0), 32'(er0));
    check("ready1", 32'(o_ready1), 32'(er1));
    check("trunc", 32'(o_trunc), 32'(m_trunc));
    if (o_tx_valid && i_tx_ready) log_q.push_back(o_tx_data);
    if (o_trunc) trunc_seen++;
    if (!i_rst) begin
      m_trunc = 1'b0;
      if (owner < 0) begin
        if (i_valid0 && i_valid1) owner = m_prio;
        else if (i_valid0)        owner = 0;
        else if (i_valid1)        owner = 1;
        m_sent = 0;
      end else if (ev && i_tx_ready) begin
        exp_log.push_back(ed);
        if (owner == 0) q0.delete(0); else q1.delete(0);
        m_sent++;
        lst = (owner == 0) ? i_last0 : i_last1;
        if (lst || m_sent == MAX_LEN) begin
          m_trunc = !lst;
          m_prio  = 1 - owner;
          owner   = -1;
        end
      end
    end
    @(posedge i_clk);
    #1;
    ready_phase++;
  endtask

  task automatic run(int max_cyc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < max_cyc) begin
      drive();
      cycle();
      n++;
    end
    check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
    repeat (2) begin
      drive();
      cycle();
    end
  endtask

  task automatic run_until_log(int n, int max_cyc);
    int k = 0;
    while (log_q.size() < n && k < max_cyc) begin
      drive();
      cycle();
      k++;
    end
    check("log_timeout", 32'(log_q.size()), 32'(n));
  endtask

  task automatic push_frame(int port, logic [7:0] first, int len, bit with_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = first + 8'(i);
      b.l = with_last && (i == len - 1);
      if (port == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic clear_logs();
    log_q.delete();
    exp_log.delete();
    trunc_seen = 0;
  endtask

  task automatic check_log(string tag);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check(tag, 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  // Asserts reset between clock edges and checks outputs clear without waiting for an edge.
  task automatic async_reset();
    #1 i_rst = 1'b1;
    #1;
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_tx_data", 32'(o_tx_data), 32'd0);
    check("rst_ready0", 32'(o_ready0), 32'd0);
    check("rst_ready1", 32'(o_ready1), 32'd0);
    check("rst_trunc", 32'(o_trunc), 32'd0);
    model_reset();
    q0.delete();
    q1.delete();
    clear_logs();
    repeat (2) begin
      drive();
      cycle();
    end
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_data0 = 8'h00; i_valid0 = 1'b0; i_last0 = 1'b0;
    i_data1 = 8'h00; i_valid1 = 1'b0; i_last1 = 1'b0;
    i_tx_ready = 1'b0;
    ready_mode = 0; ready_phase = 0; gap_mode = 1'b0;
    model_reset();
    clear_logs();
    @(posedge i_clk);
    #1;
    repeat (2) begin
      drive();
      cycle();
    end
    i_rst = 1'b0;

    // Async reset in the middle of a port-0 frame, then a lone port-1 request.
    push_frame(0, 8'hE1, 3, 1'b1);
    run_until_log(1, 20);
    async_reset();
    push_frame(1, 8'hF1, 1, 1'b1);
    drive();
    cycle();
    check("grant1_latency", 32'(o_grant), 32'h2);
    run(20);
    exp_q = {8'hF1};
    check_log("reset_then_p1");

    // Both requesters valid as reset is released.
    i_rst = 1'b1;
    clear_logs();
    push_frame(0, 8'h11, 3, 1'b1);
    push_frame(1, 8'h21, 3, 1'b1);
    drive();
    cycle();
    i_rst = 1'b0;
    run(40);
    exp_q = {8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23};
    check_log("simul");

    clear_logs();
    push_frame(0, 8'h31, 1, 1'b1);
    push_frame(1, 8'h41, 1, 1'b1);
    run(20);
    exp_q = {8'h31, 8'h41};
    check_log("simul_rr");

    // Backpressure with ready pattern 1,0,0 repeating; 4-byte frame ends exactly at MAX_LEN.
    clear_logs();
    ready_mode = 1; ready_phase = 0;
    push_frame(0, 8'h51, 4, 1'b1);
    run(40);
    ready_mode = 0;
    exp_q = {8'h51, 8'h52, 8'h53, 8'h54};
    check_log("backpressure");
    check("bp_no_trunc", 32'(trunc_seen), 32'd0);

    // Truncation of a 6-byte port-1 frame with port 0 pending.
    clear_logs();
    push_frame(1, 8'h61, 6, 1'b1);
    push_frame(0, 8'h71, 2, 1'b1);
    run(60);
    exp_q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h72, 8'h65, 8'h66};
    check_log("trunc_order");
    check("trunc_pulses", 32'(trunc_seen), 32'd1);

    // Port 0 stalls mid-frame; port 1 must wait.
    clear_logs();
    push_frame(0, 8'h81, 2, 1'b0);
    push_frame(1, 8'h91, 1, 1'b1);
    repeat (22) begin
      drive();
      cycle();
    end
    check("stall_grant", 32'(o_grant), 32'h1);
    check("stall_bytes", 32'(log_q.size()), 32'd2);
    push_frame(0, 8'h83, 1, 1'b1);
    run(20);
    exp_q = {8'h81, 8'h82, 8'h83, 8'h91};
    check_log("stall");

    // Reset mid-frame must restart arbitration with port 0 preferred.
    push_frame(0, 8'hA1, 1, 1'b1);
    run(20);
    clear_logs();
    push_frame(0, 8'hB1, 5, 1'b1);
    run_until_log(2, 20);
    async_reset();
    push_frame(0, 8'hC1, 1, 1'b1);
    push_frame(1, 8'hD1, 1, 1'b1);
    run(20);
    exp_q = {8'hC1, 8'hD1};
    check_log("reset_prio");

    // Random frames, valid gaps, random ready.
    clear_logs();
    ready_mode = 2;
    gap_mode = 1'b1;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) != 0)
        push_frame(0, 8'($urandom), $urandom_range(1, 6), 1'b1);
      if ($urandom_range(0, 3) != 0)
        push_frame(1, 8'($urandom), $urandom_range(1, 6), 1'b1);
      run(400);
    end
    exp_q = exp_log;
    check_log("rand_stream");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-aware, two-port round-robin arbiter that shares the single UART transmit byte port of `uart_wrapper` between two byte-stream requesters.
- Requester 0 is the Ethernet-to-UART bridge path; requester 1 is the `control` status/message path.
- A grant is held for a whole frame, so bytes from the two sources never interleave.
- Sits between the requesters and `uart_wrapper` (`i_data` / `i_valid` / `o_tx_ready`), in the `i_clk` domain.

## Interface
Parameters:
- `MAX_LEN`, 256: maximum bytes per grant. Grant is force-released after this many bytes even without `last`.
- `CNT_W`, 9: byte-counter width. Must satisfy 2^`CNT_W` > `MAX_LEN`.

Ports:
- `i_clk`  in  1  system clock (`CLK_50` domain)
- `i_rst`  in  1  asynchronous, active-high reset
- `i_data0`  in  8  requester 0 byte
- `i_valid0`  in  1  requester 0 byte valid
- `i_last0`  in  1  requester 0 byte is last of frame
- `o_ready0`  out  1  requester 0 byte accepted this cycle when high with `i_valid0`
- `i_data1`, `i_valid1`, `i_last1`, `o_ready1`: same as above, for requester 1
- `o_tx_data`  out  8  byte to `uart_wrapper` `i_data`
- `o_tx_valid`  out  1  to `uart_wrapper` `i_valid`
- `i_tx_ready`  in  1  from `uart_wrapper` `o_tx_ready`
- `o_grant`  out  2  one-hot current grant; 00 when idle
- `o_trunc`  out  1  one-cycle pulse when a grant is force-released at `MAX_LEN` without `last`

## Operation
- One clock `i_clk`; reset is asynchronous and active-high (`i_rst`).
- Transfer definition: a byte moves on a cycle where `o_tx_valid` and `i_tx_ready` are both 1.

FSM states: IDLE, GNT0, GNT1.
- **IDLE**
  - All of `o_tx_valid`, `o_ready0`, `o_ready1` are 0.
  - If either `i_validN` is 1, go to GNT0 or GNT1 on the next edge.
  - If both are valid, pick the port indicated by the priority pointer `prio`.
- **GNTn**
  - `o_tx_data` = `i_dataN`.
  - `o_tx_valid` = `i_validN`.
  - `o_readyN` = `i_tx_ready`; the other port's ready = 0.
  - These are combinational muxes from registered state.
- **Byte counter `cnt`**
  - Cleared on entering GNTn.
  - Increments on each transfer.
- **Grant release** happens on a transfer where `i_lastN` = 1 or `cnt` == `MAX_LEN`-1:
  - Next state is IDLE.
  - `prio` is set to the other port (round-robin).
  - `cnt` clears.
- **`o_trunc`** is registered. It is 1 for exactly the cycle after a release caused only by `cnt` == `MAX_LEN`-1 with `i_lastN` = 0.
- **Valid dropping mid-frame:** the grant is held indefinitely; the other requester waits. No timeout.
- **No switching inside GNTn:** a request from the other port never pre-empts a grant.
- **`o_grant`:** GNT0 → 01, GNT1 → 10, IDLE → 00.

## Timing
- **Reset values:** state IDLE, `prio` = 0, `cnt` = 0, `o_grant` = 00, `o_tx_valid` = 0, `o_ready0` = 0, `o_ready1` = 0, `o_trunc` = 0, `o_tx_data` = 0.
- **Reset mid-frame:** the grant is abandoned immediately and all outputs go to reset values asynchronously. Requesters must restart their frame.
- **Arbitration latency:** 1 cycle. Valid seen in IDLE at edge k gives a grant at edge k+1, so the first byte can transfer in the cycle after k+1.
- **Inter-frame gap:** one IDLE cycle minimum between consecutive grants, including back-to-back frames from the same port.
- **Throughput inside a grant:** one byte per cycle whenever `i_tx_ready` is high. The combinational path `i_tx_ready` → `o_readyN` is allowed.
- **Single-byte frame** (`last` on the first byte): GNTn lasts exactly until that transfer, then IDLE.
- **`MAX_LEN` = 1:** every transfer releases the grant. `o_trunc` pulses when `last` = 0.
- **`i_tx_ready` high with `i_validN` low:** no transfer and `cnt` unchanged.
- **`i_lastN` with no transfer:** ignored.

## Test plan
- **Reset check:** assert `i_rst` asynchronously mid-cycle → all outputs at reset values within the same cycle. Release, then assert `i_valid1` only → `o_grant` = 10 one cycle later.
- **Simultaneous requests:** both valid at reset-exit, each sending 3-byte frames (0x11,0x12,0x13 and 0x21,0x22,0x23), `i_tx_ready` always 1 → UART sees 0x11,0x12,0x13, a 1-cycle gap, then 0x21,0x22,0x23. The next simultaneous request grants port 0 again.
- **Backpressure:** port 0 sends 4 bytes while `i_tx_ready` toggles 1,0,0,1,… → each byte transferred exactly once, in order. `o_ready0` mirrors `i_tx_ready`. Port 1 stays at ready 0 throughout.
- **Truncation:** `MAX_LEN` = 4, port 1 streams 6 bytes with `last` only on byte 6 → grant released after byte 4, `o_trunc` pulses once. Port 0 (pending) is served next, then port 1 resumes with bytes 5–6.
- **Stalled requester:** port 0 drops `i_valid0` after 2 bytes for 20 cycles while port 1 is valid → `o_grant` stays 01 and no port-1 byte appears until port 0 sends `last`.
- **Reset mid-frame:** reset pulse after byte 2 of a 5-byte port-0 frame → `o_tx_valid` is 0 immediately. After release, arbitration restarts from `prio` = 0.
